scale_fifo_line_reader: RTL and testbench

Consumer at the read end of the scaler's prefetch FIFO, on the FIFO read-clock domain. It pops words using the FIFO's show-ahead handshake: data and valid are presented by the FIFO, and `rd_en` pops the head word. It re-emits the words as a framed pixel stream with ready/valid and start/end-of-line and start/end-of-frame markers. A per-frame `start` pulse triggers it, it counts `h_active` × `v_active` words, and it inserts a programmable idle gap between lines.

---
 rtl/scale_fifo_pkg.sv | 24 ++
 rtl/scale_fifo_out_slice.sv | 56 +++++
 rtl/scale_fifo_line_reader.sv | 172 +++++++++++++++++
 tb/tb_scale_fifo_line_reader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scale_fifo_pkg.sv
// Shared types and default widths for the scaler prefetch-FIFO line reader.
package scale_fifo_pkg;

  localparam int unsigned DATA_W_DFLT = 32;
  localparam int unsigned HCNT_W_DFLT = 12;
  localparam int unsigned VCNT_W_DFLT = 12;
  localparam int unsigned GAP_W_DFLT  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LINE  = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } line_state_e;

  // Framing markers carried alongside each output word.
  typedef struct packed {
    logic eof;
    logic eol;
    logic sof;
    logic sol;
  } line_marks_t;

endpackage

// File: rtl/scale_fifo_out_slice.sv
// Single-stage valid/ready output register holding a pixel word and its framing markers.
module scale_fifo_out_slice
  import scale_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_sof,
  input  logic              load_sol,
  input  logic              load_eol,
  input  logic              load_eof,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              sof,
  output logic              sol,
  output logic              eol,
  output logic              eof,
  output logic              can_load
);

  logic [DATA_W-1:0] data_q;
  line_marks_t       marks_q;
  logic              valid_q;

  // A load may coincide with the transfer of the current word.
  assign can_load = ~valid_q | ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      marks_q <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      data_q      <= load_data;
      marks_q.sof <= load_sof;
      marks_q.sol <= load_sol;
      marks_q.eol <= load_eol;
      marks_q.eof <= load_eof;
      valid_q     <= 1'b1;
    end else if (valid_q && ready) begin
      valid_q <= 1'b0;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign sof   = marks_q.sof;
  assign sol   = marks_q.sol;
  assign eol   = marks_q.eol;
  assign eof   = marks_q.eof;

endmodule

// File: rtl/scale_fifo_line_reader.sv
// Pops words from the show-ahead prefetch FIFO and re-emits them as a framed
// ready/valid pixel stream with sof/sol/eol/eof and a programmable line gap.
module scale_fifo_line_reader
  import scale_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DFLT,
  parameter int unsigned HCNT_W = HCNT_W_DFLT,
  parameter int unsigned VCNT_W = VCNT_W_DFLT,
  parameter int unsigned GAP_W  = GAP_W_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [HCNT_W-1:0] h_active,
  input  logic [VCNT_W-1:0] v_active,
  input  logic [GAP_W-1:0]  line_gap,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_vld,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_sol,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy,
  output logic              frame_done
);

  line_state_e       state_q, state_d;
  logic [HCNT_W-1:0] x_q, x_d;
  logic [VCNT_W-1:0] y_q, y_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [HCNT_W-1:0] h_q, h_d;
  logic [VCNT_W-1:0] v_q, v_d;
  logic [GAP_W-1:0]  gap_len_q, gap_len_d;
  logic              busy_q;
  logic              zero_done_q, zero_done_d;
  logic              drain_done;
  logic              rd_en;
  logic              pop;
  logic              can_load;
  logic              last_x, last_y;
  logic              mk_sol, mk_eol, mk_sof, mk_eof;

  assign last_x = (x_q == h_q - HCNT_W'(1));
  assign last_y = (y_q == v_q - VCNT_W'(1));
  assign mk_sol = (x_q == '0);
  assign mk_eol = last_x;
  assign mk_sof = mk_sol & (y_q == '0);
  assign mk_eof = mk_eol & last_y;

  // Next-state, counter updates and pop decision.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    gap_d       = gap_q;
    h_d         = h_q;
    v_d         = v_q;
    gap_len_d   = gap_len_q;
    zero_done_d = 1'b0;
    drain_done  = 1'b0;
    rd_en       = 1'b0;
    pop         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if ((h_active != '0) && (v_active != '0)) begin
            h_d       = h_active;
            v_d       = v_active;
            gap_len_d = line_gap;
            x_d       = '0;
            y_d       = '0;
            state_d   = LINE;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end

      LINE: begin
        rd_en = can_load;
        pop   = can_load & fifo_rd_vld;
        if (pop) begin
          if (last_x) begin
            x_d = '0;
            y_d = y_q + VCNT_W'(1);
            if (last_y) begin
              state_d = DRAIN;
            end else if (gap_len_q != '0) begin
              gap_d   = gap_len_q;
              state_d = GAP;
            end
          end else begin
            x_d = x_q + HCNT_W'(1);
          end
        end
      end

      GAP: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q == GAP_W'(1)) begin
          state_d = LINE;
        end
      end

      DRAIN: begin
        // Only the eof word can be left in the output register here.
        if (out_valid && out_ready && out_eof) begin
          drain_done = 1'b1;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      gap_q       <= '0;
      h_q         <= '0;
      v_q         <= '0;
      gap_len_q   <= '0;
      busy_q      <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      gap_q       <= gap_d;
      h_q         <= h_d;
      v_q         <= v_d;
      gap_len_q   <= gap_len_d;
      busy_q      <= (state_d != IDLE);
      zero_done_q <= zero_done_d;
    end
  end

  scale_fifo_out_slice #(
    .DATA_W (DATA_W)
  ) u_out_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (pop),
    .load_data (fifo_rd_data),
    .load_sof  (mk_sof),
    .load_sol  (mk_sol),
    .load_eol  (mk_eol),
    .load_eof  (mk_eof),
    .ready     (out_ready),
    .data      (out_data),
    .valid     (out_valid),
    .sof       (out_sof),
    .sol       (out_sol),
    .eol       (out_eol),
    .eof       (out_eof),
    .can_load  (can_load)
  );

  // frame_done must coincide with the eof transfer, so that path is not registered.
  assign fifo_rd_en = rd_en;
  assign busy       = busy_q;
  assign frame_done = zero_done_q | drain_done;

endmodule

// File: tb/tb_scale_fifo_line_reader.sv
// Bench for scale_fifo_line_reader: a counting show-ahead FIFO model feeds the
// reader and every transferred word is checked against frame-geometry rules.
module tb_scale_fifo_line_reader;
  import scale_fifo_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HCNT_W = 12;
  localparam int unsigned VCNT_W = 12;
  localparam int unsigned GAP_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [HCNT_W-1:0] h_active;
  logic [VCNT_W-1:0] v_active;
  logic [GAP_W-1:0]  line_gap;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd_vld;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sof, out_sol, out_eol, out_eof;
  logic              busy;
  logic              frame_done;

  int                tests = 0;
  int                fails = 0;
  logic [DATA_W-1:0] head  = '0;

  always #5 clk = ~clk;

  scale_fifo_line_reader #(
    .DATA_W (DATA_W),
    .HCNT_W (HCNT_W),
    .VCNT_W (VCNT_W),
    .GAP_W  (GAP_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .h_active     (h_active),
    .v_active     (v_active),
    .line_gap     (line_gap),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_vld  (fifo_rd_vld),
    .fifo_rd_en   (fifo_rd_en),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sof      (out_sof),
    .out_sol      (out_sol),
    .out_eol      (out_eol),
    .out_eof      (out_eof),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_data"}, 64'(out_data), 64'd0);
    chk({tag, "_marks"}, 64'({out_sof, out_sol, out_eol, out_eof}), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(frame_done), 64'd0);
    chk({tag, "_rden"}, 64'(fifo_rd_en), 64'd0);
  endtask

  // vmode: 0 always valid, 1 toggling, 2 random; rmode: 0 always ready, 1 five-cycle stall, 2 random
  task automatic run_frame(input int h, input int v, input int gap, input int vmode, input int rmode);
    int                n, popc, xfc, cyc, budget;
    bit                done, pop, xfer, prev_stall, exp_done;
    bit                e_sof, e_sol, e_eol, e_eof;
    logic [DATA_W-1:0] base;
    logic [DATA_W+3:0] obs, prev_obs, exp;
    int                pop_cyc[$];
    int                xf_cyc[$];
    n = h * v; popc = 0; xfc = 0; cyc = 0; done = 0; prev_stall = 0;
    prev_obs = '0; budget = n * 20 + 50 + n * gap;
    base = head;

    @(negedge clk);
    start = 1'b1; h_active = HCNT_W'(h); v_active = VCNT_W'(v); line_gap = GAP_W'(gap);
    fifo_rd_vld = 1'b1; out_ready = 1'b1; fifo_rd_data = head;
    #1;
    chk("start_rden", 64'(fifo_rd_en), 64'd0);

    while (!done && cyc < budget) begin
      cyc++;
      @(negedge clk);
      start = (cyc == 2);
      h_active = HCNT_W'($urandom); v_active = VCNT_W'($urandom); line_gap = GAP_W'($urandom);
      case (vmode)
        0:       fifo_rd_vld = 1'b1;
        1:       fifo_rd_vld = 1'(cyc % 2);
        default: fifo_rd_vld = ($urandom % 3) != 0;
      endcase
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(cyc >= 3 && cyc < 8);
        default: out_ready = ($urandom % 4) != 0;
      endcase
      fifo_rd_data = head;
      #1;
      pop  = fifo_rd_en & fifo_rd_vld;
      xfer = out_valid & out_ready;
      obs  = {out_data, out_sof, out_sol, out_eol, out_eof};
      if (cyc == 1) chk("busy_after_start", 64'(busy), 64'd1);
      if (prev_stall) chk("stall_hold", 64'(obs), 64'(prev_obs));
      if (out_valid && !out_ready) chk("stall_no_pop", 64'(fifo_rd_en), 64'd0);
      exp_done = xfer && (xfc == n - 1);
      chk("frame_done", 64'(frame_done), 64'(exp_done));
      if (xfer) begin
        e_sol = (xfc % h) == 0;
        e_eol = (xfc % h) == h - 1;
        e_sof = (xfc == 0);
        e_eof = (xfc == n - 1);
        exp = {DATA_W'(base + DATA_W'(xfc)), e_sof, e_sol, e_eol, e_eof};
        chk("word", 64'(obs), 64'(exp));
        xf_cyc.push_back(cyc);
        xfc++;
      end
      if (pop) begin
        pop_cyc.push_back(cyc);
        head = head + DATA_W'(1);
        popc++;
      end
      prev_stall = out_valid & ~out_ready;
      prev_obs   = obs;
      if (frame_done) done = 1;
    end

    chk("frame_finished", 64'(done), 64'd1);
    chk("pop_count", 64'(popc), 64'(n));
    chk("xfer_count", 64'(xfc), 64'(n));

    if (vmode == 0 && rmode == 0 && popc == n && xfc == n) begin
      chk("first_pop", 64'(pop_cyc[0]), 64'd1);
      for (int k = 0; k < n - 1; k++)
        chk("pop_spacing", 64'(pop_cyc[k+1] - pop_cyc[k]), 64'(((k % h) == h - 1) ? gap + 1 : 1));
      for (int k = 0; k < n; k++)
        chk("out_latency", 64'(xf_cyc[k] - pop_cyc[k]), 64'd1);
    end

    @(negedge clk);
    start = 1'b0; fifo_rd_vld = 1'b1; out_ready = 1'b1; fifo_rd_data = head;
    #1;
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_rden", 64'(fifo_rd_en), 64'd0);
    chk("post_done", 64'(frame_done), 64'd0);
  endtask

  task automatic zero_start(input int h, input int v);
    @(negedge clk);
    start = 1'b1; h_active = HCNT_W'(h); v_active = VCNT_W'(v); fifo_rd_vld = 1'b1;
    #1;
    chk("zs_done_early", 64'(frame_done), 64'd0);
    chk("zs_rden0", 64'(fifo_rd_en), 64'd0);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("zs_done_pulse", 64'(frame_done), 64'd1);
    chk("zs_busy", 64'(busy), 64'd0);
    chk("zs_rden", 64'(fifo_rd_en), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("zs_done_once", 64'(frame_done), 64'd0);
      chk("zs_busy_low", 64'(busy), 64'd0);
      chk("zs_rden_low", 64'(fifo_rd_en), 64'd0);
    end
  endtask

  task automatic abort_frame();
    int popc;
    bit hit;
    popc = 0; hit = 0;
    @(negedge clk);
    start = 1'b1; h_active = HCNT_W'(4); v_active = VCNT_W'(4); line_gap = '0;
    fifo_rd_vld = 1'b1; out_ready = 1'b1; fifo_rd_data = head;
    #1;
    for (int c = 0; c < 60 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0; fifo_rd_data = head;
      #1;
      if (fifo_rd_en && fifo_rd_vld) begin
        head = head + DATA_W'(1);
        popc++;
      end
      if (popc == 5) hit = 1;
    end
    chk("abort_reached", 64'(hit), 64'd1);
    @(negedge clk);
    rst_n = 1'b0; fifo_rd_data = head;
    #1;
    // The FIFO still pops if enable is high during the reset cycle.
    if (fifo_rd_en && fifo_rd_vld) head = head + DATA_W'(1);
    @(negedge clk);
    rst_n = 1'b1; fifo_rd_data = head;
    #1;
    chk_reset_outputs("abort");
    chk("abort_state", 64'(dut.state_q), 64'(IDLE));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; h_active = '0; v_active = '0; line_gap = '0;
    fifo_rd_data = '0; fifo_rd_vld = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(4, 2, 0, 0, 0);
    run_frame(4, 2, 3, 0, 0);
    run_frame(4, 3, 1, 0, 1);
    run_frame(4, 2, 0, 1, 0);
    zero_start(0, 5);
    zero_start(3, 0);
    run_frame(1, 1, 0, 0, 0);
    run_frame(1, 3, 2, 2, 2);
    abort_frame();
    run_frame(4, 4, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      run_frame(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    run_frame(4095, 2, 255, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
